// File: rtl/seg7_scan_driver_if.sv
// Bundle between a datapath and the seven-segment scan driver.
// The datapath side (master) supplies the digits and controls. The driver side (slave) returns the pin levels.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic                  en;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;

    modport master (
        output load, value, dp_in, blank_lz, en,
        input  seg, dp, an
    );

    modport slave (
        input  load, value, dp_in, blank_lz, en,
        output seg, dp, an
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex seven-segment driver with shadow registers, leading-zero blanking and per-digit dp.
// Segments, dp and digit enables are active-low and come straight from registers, so they do not glitch.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    seg7_scan_driver_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_driver: DIGITS must be in 1..8");
    end
    if (REFRESH_DIV < 1) begin : g_bad_div
        $error("seg7_scan_driver: REFRESH_DIV must be at least 1");
    end

    logic [4*DIGITS-1:0] val_q;
    logic [DIGITS-1:0]   dp_q;
    logic [PW-1:0]       presc_q;
    logic [PW-1:0]       presc_d;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       idx_d;
    logic                wrap;

    logic [DIGITS-1:0]   lz;
    logic                zero_above;
    logic [3:0]          nib;
    logic                dp_sel;
    logic                blank;
    logic [6:0]          seg_d;
    logic                dp_d;
    logic [DIGITS-1:0]   an_d;

    logic [6:0]          seg_p0;
    logic                dp_p0;
    logic [DIGITS-1:0]   an_p0;

    // Hex nibble to active-low {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h01;
            4'h1:    s = 7'h4F;
            4'h2:    s = 7'h12;
            4'h3:    s = 7'h06;
            4'h4:    s = 7'h4C;
            4'h5:    s = 7'h24;
            4'h6:    s = 7'h20;
            4'h7:    s = 7'h0F;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h04;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h60;
            4'hC:    s = 7'h31;
            4'hD:    s = 7'h42;
            4'hE:    s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            dp_q    <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (bus.load) begin
                val_q <= bus.value;
                dp_q  <= bus.dp_in;
            end
        end
    end

    // The scan keeps running while the display is disabled, so re-enabling resumes mid-frame.
    always_comb begin
        wrap    = (presc_q == PRESC_LAST);
        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        nib        = 4'h0;
        dp_sel     = 1'b0;
        blank      = 1'b0;
        an_d       = '1;
        seg_d      = 7'h7F;
        dp_d       = 1'b1;

        // lz[k]: nibble k and every nibble above it are zero.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (val_q[4*k +: 4] == 4'h0);
            lz[k]      = zero_above;
        end

        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib     = val_q[4*k +: 4];
                dp_sel  = dp_q[k];
                blank   = bus.blank_lz && (k != 0) && lz[k];
                an_d[k] = 1'b0;
            end
        end

        if (bus.en) begin
            seg_d = blank ? 7'h7F : hex_to_seg(nib);
            dp_d  = ~dp_sel;
        end else begin
            an_d  = '1;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_p0 <= 7'h7F;
            dp_p0  <= 1'b1;
            an_p0  <= '1;
        end else begin
            seg_p0 <= seg_d;
            dp_p0  <= dp_d;
            an_p0  <= an_d;
        end
    end

    assign bus.seg = seg_p0;
    assign bus.dp  = dp_p0;
    assign bus.an  = an_p0;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4): a per-edge reference model queues the
// expected pin levels and a negedge monitor compares them against the DUT.
module tb_seg7_scan_driver;
    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;

    typedef struct packed {
        logic [DIGITS-1:0] an;
        logic [6:0]        seg;
        logic              dp;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus();

    seg7_scan_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t                exp_q[$];
    int                  n_checks = 0;
    int                  n_fail   = 0;
    int unsigned         edge_n   = 0;
    logic [4*DIGITS-1:0] m_val    = '0;
    logic [DIGITS-1:0]   m_dp     = '0;

    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        string      s;
        logic [6:0] m;
        int         c;
        s = lit[h];
        m = '0;
        for (int i = 0; i < s.len(); i++) begin
            c = int'(s[i]) - 97;
            m[6-c] = 1'b1;
        end
        return ~m;
    endfunction

    function automatic int digit_at(input int unsigned n);
        return int'(((n - 1) / REFRESH_DIV) % DIGITS);
    endfunction

    function automatic exp_t model_out(input int unsigned n, input logic [4*DIGITS-1:0] v,
                                       input logic [DIGITS-1:0] d, input logic en, input logic blz);
        exp_t                e;
        int                  dig;
        logic [4*DIGITS-1:0] upper;
        e.an  = '1;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (en) begin
            dig   = digit_at(n);
            upper = v >> (4 * dig);
            e.an  = ~(DIGITS'(1) << dig);
            e.seg = (blz && dig != 0 && upper == 0) ? 7'h7F : ref_seg(upper[3:0]);
            e.dp  = ~d[dig];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: what the pins must show after this edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            edge_n = 0;
            m_val  = '0;
            m_dp   = '0;
            exp_q.push_back({{DIGITS{1'b1}}, 7'h7F, 1'b1});
        end else begin
            edge_n++;
            exp_q.push_back(model_out(edge_n, m_val, m_dp, bus.en, bus.blank_lz));
            if (bus.load) begin
                m_val = bus.value;
                m_dp  = bus.dp_in;
            end
        end
    end

    always @(negedge reset_n) exp_q.delete();

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an",  32'(bus.an),  32'(e.an));
            check("seg", 32'(bus.seg), 32'(e.seg));
            check("dp",  32'(bus.dp),  32'(e.dp));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] d);
        bus.load  = 1'b1;
        bus.value = v;
        bus.dp_in = d;
        step(1);
        bus.load  = 1'b0;
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_an"},  32'(bus.an),  32'({DIGITS{1'b1}}));
        check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        check({tag, "_dp"},  32'(bus.dp),  32'h1);
    endtask

    initial begin
        bool_reached_init();
    end

    task automatic bool_reached_init();
        bit reached;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;
        bus.en       = 1'b1;

        #1 reset_n = 1'b0;
        #1 check_reset_pins("rst_async");
        step(3);
        reset_n = 1'b1;
        step(2);

        // Scan of a mixed value with one decimal point.
        do_load(16'h12AF, 4'b0100);
        step(20);

        // Leading-zero blanking.
        bus.blank_lz = 1'b1;
        do_load(16'h0050, 4'b0000);
        step(16);
        do_load(16'h0000, 4'b0000);
        step(16);
        bus.blank_lz = 1'b0;
        step(16);

        // Decode sweep on digit 0; repeated identical loads along the way.
        for (int v = 0; v < 16; v++) begin
            do_load(16'(v), 4'b0001);
            do_load(16'(v), 4'b0001);
            step(15);
        end

        // Enable toggling and a load in the middle of a dwell.
        do_load(16'h4C3E, 4'b1001);
        step(6);
        bus.en = 1'b0;
        step(5);
        bus.en = 1'b1;
        step(9);
        do_load(16'h9876, 4'b1010);
        step(10);

        // Asynchronous reset while digit 2 is on the pins.
        reached = 1'b0;
        for (int i = 0; i < 64 && !reached; i++) begin
            if (edge_n > 0 && digit_at(edge_n) == 2) reached = 1'b1;
            else step(1);
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL reach_digit2: got edge %0d, required digit 2 within 64 cycles", edge_n);
        end
        #2 reset_n = 1'b0;
        #1 check_reset_pins("rst_mid");
        step(2);
        reset_n = 1'b1;
        step(20);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bus.load  = ($urandom_range(7) == 0);
            bus.value = ($urandom_range(3) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
            bus.dp_in = 4'($urandom);
            if ($urandom_range(15) == 0) bus.en = ~bus.en;
            if ($urandom_range(31) == 0) bus.blank_lz = ~bus.blank_lz;
            step(1);
        end
        bus.load = 1'b0;
        bus.en   = 1'b1;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed hexadecimal seven-segment display driver. It latches a DIGITS-nibble value on a load strobe and scans one digit at a time through shared active-low segment lines and active-low digit enables. It adds optional leading-zero blanking, per-digit decimal points and a display enable. It sits between the datapath and the board display pins and supersedes the single-digit combinational hex decoder.

## Interface
- DIGITS, 4: number of digits scanned; 1 to 8.
- REFRESH_DIV, 1000: clock cycles each digit stays selected; must be at least 1.
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset. The design has one clock, and reset is asynchronous and active-low.
- load  input  1  when 1 at a clock edge, captures value and dp_in into the shadow registers.
- value  input  4*DIGITS  hex digits; nibble k is value[4k+3:4k], and digit 0 is the least significant.
- dp_in  input  DIGITS  decimal point request per digit; 1 means lit.
- blank_lz  input  1  1 enables leading-zero suppression.
- en  input  1  0 blanks the whole display.
- seg  output  7  segments {a,b,c,d,e,f,g}, with a at bit 6; active-low, so 0 means lit.
- dp  output  1  decimal point, active-low.
- an  output  DIGITS  digit enables, active-low; exactly one bit is 0 while the display is enabled.

## Operation
- Shadow registers: val_q (4*DIGITS bits) and dp_q (DIGITS bits). Loaded when load=1. Reset value 0. The display reads only the shadow registers.
- Prescaler: counts 0 to REFRESH_DIV-1, then wraps to 0. Width is max(1, $clog2(REFRESH_DIV)).
- Digit index idx: advances on the cycle the prescaler wraps. The sequence is 0, 1, …, DIGITS-1, 0. The prescaler and idx run regardless of en.
- Decode, listing the lit segments for each nibble:
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg
  - 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg
  - C adef, d bcdeg, E adefg, F aefg
- Leading-zero blanking: digit k>0 is blanked when blank_lz=1 and nibbles k through DIGITS-1 are all zero.
  - A blanked digit shows seg=7'h7F.
  - Its dp still follows dp_q[k].
  - Its an bit is still driven low.
  - Digit 0 is never blanked.
- en=0: an is all ones, seg=7'h7F, dp=1.
- Output registers: seg, dp and an are registered every cycle from idx, val_q, dp_q, en and blank_lz. The outputs are glitch-free.

## Timing
- Reset, asserted asynchronously: an=all ones, seg=7'h7F, dp=1, idx=0, prescaler=0, val_q=0, dp_q=0. This holds while reset_n=0.
- After reset release:
  - The first edge registers digit 0, giving an=...1110.
  - Digit 0 stays selected for REFRESH_DIV cycles, and every digit after it does the same.
- An output change lags the idx change by 1 cycle.
- Load latency: with load=1 at edge N, val_q updates at edge N. The currently selected digit shows the new value from edge N+1.
- load coinciding with an idx advance: the newly selected digit shows the new value from edge N+1. No stale or mixed frame appears after that.
- Repeated load with the same data causes no visible change.
- REFRESH_DIV=1: idx advances every cycle.
- DIGITS=1: idx stays 0 and an is held at 1'b0 while enabled.
- en change at edge N: takes effect on the outputs at edge N+1. Scan position is unaffected.
- reset_n asserted mid-scan: the outputs take their reset values immediately. After release the scan restarts at digit 0 with a full REFRESH_DIV dwell.

## Test plan
Directed tests use DIGITS=4 and REFRESH_DIV=4.
1. Reset check: hold reset_n=0 → an=4'b1111, seg=7'h7F, dp=1. Release reset_n → an=4'b1110 and seg=7'h01 (digit 0 showing 0) after 1 edge.
2. Four-digit scan:
   - Stimulus: load value=16'h12AF, dp_in=4'b0100, en=1, blank_lz=0.
   - Required an sequence: 1110, 1101, 1011, 0111, with each state lasting 4 cycles.
   - Required seg in the same order: 7'h38, 7'h08, 7'h12, 7'h4F.
   - Required dp: 0 only while an=1011.
3. Leading-zero blanking:
   - value=16'h0050 with blank_lz=1 → digits 3 and 2 show seg=7'h7F, digit 1 shows 7'h24, digit 0 shows 7'h01.
   - value=0 → only digit 0 is lit, with seg=7'h01.
   - blank_lz=0 → digits 3 and 2 show 7'h01.
4. Decode sweep: load each nibble 0 to F into digit 0 → seg matches the decode list.
5. Enable and load timing:
   - Drive en=0 → an=1111 next cycle. Drive en=1 → the digit selected by the continuing scan reappears.
   - Load during a digit's dwell → new seg exactly 1 cycle after the load edge.
6. Reset mid-scan: assert reset_n asynchronously while digit 2 is active → immediate reset outputs and val_q cleared. After release → digit 0 is selected for 4 cycles.
